rvc_align_expand: RTL and testbench

- Sequential fetch-side successor to the combinational RVC expander.
- Accepts fetch words holding mixed 16/32-bit RISC-V instructions and buffers them as halfwords.
- Re-aligns 32-bit instructions that span fetch-word boundaries and expands RV32C instructions to 32-bit encodings.
- Issues one 32-bit instruction per cycle with its PC to decode over a valid/ready handshake.

---
 rtl/rvc_pkg.sv | 37 +++
 rtl/rvc_decompress.sv | 121 ++++++++++++
 rtl/rvc_align_expand.sv | 123 ++++++++++++
 tb/tb_rvc_align_expand.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_pkg.sv
// Shared RISC-V constants and types for the fetch-side RVC aligner and
// the 16-to-32 bit expander.
package rvc_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b10,
    Q3 = 2'b11
  } quadrant_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Upper half of inst_data when a compressed encoding is rejected.
  localparam halfword_t ILLEGAL_PAD = 16'h0000;

endpackage

// File: rtl/rvc_decompress.sv
// Combinational RV32C to RV32I expander; flags reserved, F/D and
// RV64-only encodings as illegal.
module rvc_decompress
  import rvc_pkg::*;
(
  input  halfword_t   c,
  output logic [31:0] inst,
  output logic        illegal
);

  quadrant_e   q;
  logic [4:0]  rd, rs2, rdp, rs2p;
  logic [11:0] imm6s, lwoff, joff, lwspoff, swspoff;
  logic [9:0]  nzuimm, imm16;

  assign q       = quadrant_e'(c[1:0]);
  assign rd      = c[11:7];
  assign rs2     = c[6:2];
  assign rdp     = {2'b01, c[9:7]};
  assign rs2p    = {2'b01, c[4:2]};
  assign imm6s   = {{6{c[12]}}, c[12], c[6:2]};
  assign nzuimm  = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lwoff   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign joff    = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign imm16   = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign lwspoff = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign swspoff = {4'b0, c[8:7], c[12:9], 2'b00};

  always_comb begin
    inst    = 32'h0;
    illegal = 1'b0;
    case (q)
      Q0: begin
        case (c[15:13])
          3'b000: begin
            inst    = {2'b00, nzuimm, 5'd2, F3_ADD, rs2p, OP_IMM};
            illegal = (nzuimm == 10'd0);
          end
          3'b010: inst = {lwoff, rdp, F3_LW, rs2p, LOAD};
          3'b110: inst = {lwoff[11:5], rs2p, rdp, F3_LW, lwoff[4:0], STORE};
          default: illegal = 1'b1;
        endcase
      end
      Q1: begin
        case (c[15:13])
          3'b000: inst = {imm6s, rd, F3_ADD, rd, OP_IMM};
          3'b001, 3'b101:
            inst = {joff[11], joff[10:1], joff[11], {8{joff[11]}},
                    (c[15] ? 5'd0 : 5'd1), JAL};
          3'b010: inst = {imm6s, 5'd0, F3_ADD, rd, OP_IMM};
          3'b011: begin
            if (rd == 5'd2) begin
              inst    = {{2{c[12]}}, imm16, 5'd2, F3_ADD, 5'd2, OP_IMM};
              illegal = (imm16 == 10'd0);
            end else begin
              inst    = {{14{c[12]}}, c[12], c[6:2], rd, LUI};
              illegal = ({c[12], c[6:2]} == 6'd0);
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                inst    = {7'b0000000, c[6:2], rdp, F3_SR, rdp, OP_IMM};
                illegal = c[12];
              end
              2'b01: begin
                inst    = {7'b0100000, c[6:2], rdp, F3_SR, rdp, OP_IMM};
                illegal = c[12];
              end
              2'b10: inst = {imm6s, rdp, F3_AND, rdp, OP_IMM};
              default: begin
                // c[12]=1 selects subw/addw, which only exist on RV64.
                illegal = c[12];
                case (c[6:5])
                  2'b00:   inst = {7'b0100000, rs2p, rdp, F3_ADD, rdp, OP};
                  2'b01:   inst = {7'b0000000, rs2p, rdp, F3_XOR, rdp, OP};
                  2'b10:   inst = {7'b0000000, rs2p, rdp, F3_OR,  rdp, OP};
                  default: inst = {7'b0000000, rs2p, rdp, F3_AND, rdp, OP};
                endcase
              end
            endcase
          end
          default:
            inst = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp,
                    (c[13] ? F3_BNE : F3_BEQ), c[11:10], c[4:3], c[12], BRANCH};
        endcase
      end
      Q2: begin
        case (c[15:13])
          3'b000: begin
            inst    = {7'b0000000, c[6:2], rd, F3_SLL, rd, OP_IMM};
            illegal = c[12];
          end
          3'b010: begin
            inst    = {lwspoff, 5'd2, F3_LW, rd, LOAD};
            illegal = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                inst    = {12'd0, rd, F3_ADD, 5'd0, JALR};
                illegal = (rd == 5'd0);
              end else begin
                inst = {7'b0, rs2, 5'd0, F3_ADD, rd, OP};
              end
            end else if (rs2 == 5'd0) begin
              inst = (rd == 5'd0) ? {12'd1, 5'd0, 3'b000, 5'd0, SYSTEM}
                                  : {12'd0, rd, F3_ADD, 5'd1, JALR};
            end else begin
              inst = {7'b0, rs2, rd, F3_ADD, rd, OP};
            end
          end
          3'b110: inst = {swspoff[11:5], rs2, 5'd2, F3_LW, swspoff[4:0], STORE};
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rvc_align_expand.sv
// Halfword fetch buffer that realigns boundary-spanning 32-bit instructions
// and issues one expanded instruction per cycle to decode.
module rvc_align_expand
  import rvc_pkg::*;
#(
  parameter int FETCH_W   = 32,
  parameter int BUF_WORDS = 2,
  parameter int PC_W      = 32,
  parameter bit ENABLE_C  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic [PC_W-1:0]    fetch_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [PC_W-1:0]    inst_pc,
  output logic               inst_is_c,
  output logic               inst_illegal
);

  localparam int HW    = FETCH_W / 16;
  localparam int CAP   = BUF_WORDS * HW;
  localparam int PTR_W = $clog2(CAP);
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int OFF_W = $clog2(FETCH_W / 8);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic ptr_t wrap(input logic [31:0] p);
    return ptr_t'(p % CAP);
  endfunction

  halfword_t        hbuf [CAP];
  ptr_t             head, tail;
  cnt_t             count, npush, pushed, popped;
  logic [PC_W-1:0]  head_pc, pc_step;
  logic [OFF_W-2:0] k;
  halfword_t        hw0, hw1;
  logic             is32, accept, issue;
  logic [31:0]      exp_inst;
  logic             exp_illegal, c_illegal;
  logic             unused_pc_bit;

  assign unused_pc_bit = fetch_pc[0];
  assign k        = fetch_pc[OFF_W-1:1];
  assign npush    = cnt_t'(HW) - cnt_t'(k);
  assign hw0      = hbuf[head];
  assign hw1      = hbuf[wrap(32'(head) + 32'd1)];
  assign is32     = (hw0[1:0] == 2'b11);

  assign fetch_ready = (cnt_t'(CAP) - count) >= cnt_t'(HW);
  assign inst_valid  = !rst && !flush &&
                       ((count != '0 && !is32) || (count >= cnt_t'(2) && is32));
  assign accept  = fetch_valid && fetch_ready;
  assign issue   = inst_valid && inst_ready;
  assign pushed  = accept ? npush : '0;
  assign popped  = issue ? (is32 ? cnt_t'(2) : cnt_t'(1)) : '0;
  assign pc_step = is32 ? PC_W'(4) : PC_W'(2);

  rvc_decompress u_dec (
    .c       (hw0),
    .inst    (exp_inst),
    .illegal (exp_illegal)
  );

  assign c_illegal = exp_illegal || !ENABLE_C;

  always_comb begin
    inst_data    = 32'h0;
    inst_is_c    = 1'b0;
    inst_illegal = 1'b0;
    if (inst_valid) begin
      if (is32) begin
        inst_data = {hw1, hw0};
      end else begin
        inst_is_c = 1'b1;
        if (c_illegal) begin
          inst_illegal = 1'b1;
          inst_data    = {ILLEGAL_PAD, hw0};
        end else begin
          inst_data = exp_inst;
        end
      end
    end
  end

  assign inst_pc = head_pc;

  // Storage is unreset; only halfwords at or above the fetch offset land.
  always_ff @(posedge clk) begin
    if (accept && !rst && !flush) begin
      for (int i = 0; i < HW; i++) begin
        if (i >= int'(k))
          hbuf[wrap(32'(tail) + 32'(i) - 32'(k))] <= fetch_data[16*i +: 16];
      end
    end
  end

  // Pointer, occupancy and PC bookkeeping; flush and reset override traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      if (rst) head_pc <= '0;
    end else begin
      if (accept) tail <= wrap(32'(tail) + 32'(npush));
      if (issue)  head <= wrap(32'(head) + 32'(popped));
      count <= count + pushed - popped;
      if (accept && count == '0)
        head_pc <= {fetch_pc[PC_W-1:1], 1'b0};
      else if (issue)
        head_pc <= head_pc + pc_step;
    end
  end

endmodule

// File: tb/tb_rvc_align_expand.sv
// Self-checking bench: a halfword-queue model with a field-level RVC
// decoder predicts every handshake and issued instruction.
module tb_rvc_align_expand;

  localparam int FETCH_W = 32;
  localparam int HW      = FETCH_W / 16;
  localparam int CAP     = 2 * HW;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_ready, inst_valid, inst_ready;
  logic        inst_is_c, inst_illegal;
  logic [31:0] fetch_data, fetch_pc, inst_data, inst_pc;

  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          errors = 0;
  int          checks = 0;
  bit          const_en = 1'b0;
  logic [31:0] const_val;

  rvc_align_expand dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_data   (fetch_data),
    .fetch_pc     (fetch_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .inst_is_c    (inst_is_c),
    .inst_illegal (inst_illegal)
  );

  always #5 clk = ~clk;

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  // Reference expansion from the RV32C field definitions.
  task automatic ref_expand(input logic [15:0] c, output logic [31:0] ins, output logic ill);
    int f3, rd, rs2, rdp, rs2p, s6, imm;
    f3   = int'(c[15:13]);
    rd   = int'(c[11:7]);
    rs2  = int'(c[6:2]);
    rdp  = 8 + int'(c[9:7]);
    rs2p = 8 + int'(c[4:2]);
    s6   = sext(int'(c[12]) * 32 + int'(c[6:2]), 6);
    ins  = 32'h0;
    ill  = 1'b0;
    case (int'(c[1:0]))
      0: case (f3)
           0: begin
             imm = int'(c[10:7]) * 64 + int'(c[12:11]) * 16 + int'(c[5]) * 8 + int'(c[6]) * 4;
             ins = enc_i(imm, 2, 0, rs2p, 7'h13);
             ill = (imm == 0);
           end
           2: ins = enc_i(int'(c[5]) * 64 + int'(c[12:10]) * 8 + int'(c[6]) * 4, rdp, 2, rs2p, 7'h03);
           6: ins = enc_s(int'(c[5]) * 64 + int'(c[12:10]) * 8 + int'(c[6]) * 4, rs2p, rdp);
           default: ill = 1'b1;
         endcase
      1: case (f3)
           0: ins = enc_i(s6, rd, 0, rd, 7'h13);
           1, 5: begin
             imm = sext(int'(c[12]) * 2048 + int'(c[8]) * 1024 + int'(c[10:9]) * 256 +
                        int'(c[6]) * 128 + int'(c[7]) * 64 + int'(c[2]) * 32 +
                        int'(c[11]) * 16 + int'(c[5:3]) * 2, 12);
             ins = enc_j(imm, (f3 == 1) ? 1 : 0);
           end
           2: ins = enc_i(s6, 0, 0, rd, 7'h13);
           3: if (rd == 2) begin
                imm = sext(int'(c[12]) * 512 + int'(c[4:3]) * 128 + int'(c[5]) * 64 +
                           int'(c[2]) * 32 + int'(c[6]) * 16, 10);
                ins = enc_i(imm, 2, 0, 2, 7'h13);
                ill = (imm == 0);
              end else begin
                imm = s6;
                ins = {imm[19:0], c[11:7], 7'h37};
                ill = (s6 == 0);
              end
           4: case (int'(c[11:10]))
                0: begin ins = enc_i(rs2, rdp, 5, rdp, 7'h13); ill = c[12]; end
                1: begin ins = enc_i(1024 + rs2, rdp, 5, rdp, 7'h13); ill = c[12]; end
                2: ins = enc_i(s6, rdp, 7, rdp, 7'h13);
                default: begin
                  ill = c[12];
                  case (int'(c[6:5]))
                    0: ins = enc_r(32, rs2p, rdp, 0, rdp);
                    1: ins = enc_r(0, rs2p, rdp, 4, rdp);
                    2: ins = enc_r(0, rs2p, rdp, 6, rdp);
                    default: ins = enc_r(0, rs2p, rdp, 7, rdp);
                  endcase
                end
              endcase
           default: begin
             imm = sext(int'(c[12]) * 256 + int'(c[6:5]) * 64 + int'(c[2]) * 32 +
                        int'(c[11:10]) * 8 + int'(c[4:3]) * 2, 9);
             ins = enc_b(imm, rdp, (f3 == 7) ? 1 : 0);
           end
         endcase
      2: case (f3)
           0: begin ins = enc_i(rs2, rd, 1, rd, 7'h13); ill = c[12]; end
           2: begin
             ins = enc_i(int'(c[3:2]) * 64 + int'(c[12]) * 32 + int'(c[6:4]) * 4, 2, 2, rd, 7'h03);
             ill = (rd == 0);
           end
           4: if (c[12] == 1'b0) begin
                if (rs2 == 0) begin ins = enc_i(0, rd, 0, 0, 7'h67); ill = (rd == 0); end
                else ins = enc_r(0, rs2, 0, 0, rd);
              end else begin
                if (rs2 == 0 && rd == 0) ins = 32'h00100073;
                else if (rs2 == 0) ins = enc_i(0, rd, 0, 1, 7'h67);
                else ins = enc_r(0, rs2, rd, 0, rd);
              end
           6: ins = enc_s(int'(c[8:7]) * 64 + int'(c[12:9]) * 4, rs2, 2);
           default: ill = 1'b1;
         endcase
      default: ill = 1'b1;
    endcase
  endtask

  function automatic bit model_valid();
    if (mq.size() == 0) return 1'b0;
    if (mq[0].hw[1:0] != 2'b11) return 1'b1;
    return mq.size() >= 2;
  endfunction

  // One clock: drive, compare against the model, then advance the model.
  task automatic step(input logic fv, input logic [31:0] fd, input logic [31:0] fpc,
                      input logic ir, input logic fl, input logic rs);
    logic        exp_fr, exp_v, exp_c, exp_ill;
    logic [31:0] exp_d, exp_pc, npc;
    int          k;
    @(negedge clk);
    fetch_valid = fv; fetch_data = fd; fetch_pc = fpc;
    inst_ready = ir; flush = fl; rst = rs;
    #1;
    exp_fr = (CAP - mq.size()) >= HW;
    exp_v  = !rs && !fl && model_valid();
    checks++;
    if (fetch_ready !== exp_fr) begin
      errors++;
      $display("[TB] FAIL fetch_ready: got %b want %b at %0t", fetch_ready, exp_fr, $time);
    end
    checks++;
    if (inst_valid !== exp_v) begin
      errors++;
      $display("[TB] FAIL inst_valid: got %b want %b at %0t", inst_valid, exp_v, $time);
    end
    if (exp_v) begin
      exp_pc = mq[0].pc;
      if (mq[0].hw[1:0] == 2'b11) begin
        exp_d = {mq[1].hw, mq[0].hw}; exp_c = 1'b0; exp_ill = 1'b0;
      end else begin
        ref_expand(mq[0].hw, exp_d, exp_ill);
        exp_c = 1'b1;
        if (exp_ill) exp_d = {16'h0, mq[0].hw};
      end
      checks++;
      if (inst_data !== exp_d) begin
        errors++;
        $display("[TB] FAIL inst_data: got %h want %h (hw %h) at %0t", inst_data, exp_d, mq[0].hw, $time);
      end
      checks++;
      if (inst_pc !== exp_pc) begin
        errors++;
        $display("[TB] FAIL inst_pc: got %h want %h at %0t", inst_pc, exp_pc, $time);
      end
      checks++;
      if (inst_is_c !== exp_c) begin
        errors++;
        $display("[TB] FAIL inst_is_c: got %b want %b at %0t", inst_is_c, exp_c, $time);
      end
      checks++;
      if (inst_illegal !== exp_ill) begin
        errors++;
        $display("[TB] FAIL inst_illegal: got %b want %b at %0t", inst_illegal, exp_ill, $time);
      end
      if (const_en) begin
        checks++;
        if (inst_data !== const_val) begin
          errors++;
          $display("[TB] FAIL known_expansion: got %h want %h", inst_data, const_val);
        end
        const_en = 1'b0;
      end
    end
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      npc = (mq.size() > 0) ? mq[$].pc + 32'd2 : (fpc & ~32'd1);
      if (exp_v && ir) begin
        if (mq[0].hw[1:0] == 2'b11) void'(mq.pop_front());
        void'(mq.pop_front());
      end
      if (fv && exp_fr) begin
        k = int'(fpc % (FETCH_W / 8)) / 2;
        for (int i = k; i < HW; i++) begin
          mq.push_back('{hw: fd[16*i +: 16], pc: npc});
          npc = npc + 32'd2;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && mq.size() > 0; i++) step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; inst_ready = 1'b0;
    fetch_data = '0; fetch_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_ready !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got ready=%b valid=%b want 1 0", fetch_ready, inst_valid);
    end
    checks++;
    if (inst_data !== 32'h0 || inst_is_c !== 1'b0 || inst_illegal !== 1'b0 || inst_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%h c=%b ill=%b pc=%h want zeros",
               inst_data, inst_is_c, inst_illegal, inst_pc);
    end
  endtask

  task automatic test_basic();
    step(1, 32'h00000013, 32'h0, 1, 0, 0);
    drain();
    step(1, 32'h00014501, 32'h0, 1, 0, 0);
    drain();
    step(1, 32'h00010000, 32'h0, 1, 0, 0);
    drain();
  endtask

  task automatic test_spanning();
    step(1, 32'h05134501, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(1, 32'h00010015, 32'h4, 1, 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      step(1, 32'h00100093 + (i << 20), 32'h40 + 4 * i, 0, 0, 0);
    drain();
  endtask

  task automatic test_flush_and_reset();
    step(1, 32'h05134501, 32'h0, 1, 0, 0);
    step(1, 32'h00010000, 32'h102, 1, 1, 0);
    step(1, 32'h00010000, 32'h102, 1, 0, 0);
    drain();
    step(1, 32'h05134501, 32'h0, 1, 0, 0);
    step(1, 32'h00010000, 32'h102, 1, 0, 1);
    step(1, 32'h00010000, 32'h102, 1, 0, 0);
    drain();
  endtask

  task automatic test_known_expansions();
    logic [15:0] hws [7];
    logic [31:0] want [7];
    hws = '{16'h4501, 16'h0001, 16'h1141, 16'hc606, 16'h40b2, 16'h8082, 16'h852e};
    want = '{32'h00000513, 32'h00000013, 32'hff010113, 32'h00112623,
             32'h00c12083, 32'h00008067, 32'h00b00533};
    for (int i = 0; i < 7; i++) begin
      step(1, {16'h0001, hws[i]}, 32'h0, 0, 0, 0);
      const_en  = 1'b1;
      const_val = want[i];
      drain();
    end
    step(1, {16'h0001, 16'h9002}, 32'h0, 0, 0, 0);
    const_en  = 1'b1;
    const_val = 32'h00100073;
    drain();
  endtask

  task automatic test_random();
    logic [31:0] w, pc;
    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 2) == 0) w[1:0] = 2'b11;
      pc = (pc + 32'd4) & ~32'd3;
      if ($urandom_range(0, 3) == 0) pc = pc | 32'd2;
      step($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spanning();
    test_back_to_back();
    test_flush_and_reset();
    test_known_expansions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
